// File: rtl/lock_sequence_ctrl.sv
// Combination-lock sequencer: digit entry, unlock hold, failed-attempt lockout.
// Define LOCK_PROG_EN to allow reprogramming the code while unlocked.
module lock_sequence_ctrl #(
    parameter int                    CODE_LEN      = 3,
    parameter logic [3*CODE_LEN-1:0] CODE          = 9'o527,
    parameter int                    MAX_FAIL      = 3,
    parameter int                    UNLOCK_TICKS  = 5,
    parameter int                    LOCKOUT_TICKS = 10,
    parameter int                    ENTRY_TICKS   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tick,
    input  logic                            enter,
    input  logic [2:0]                      code_in,
    output logic                            unlock,
    output logic                            lockout,
    output logic [2:0]                      digit_idx,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

    localparam int FW   = $clog2(MAX_FAIL + 1);
    localparam int MAXT = (UNLOCK_TICKS > LOCKOUT_TICKS)
                          ? ((UNLOCK_TICKS > ENTRY_TICKS) ? UNLOCK_TICKS : ENTRY_TICKS)
                          : ((LOCKOUT_TICKS > ENTRY_TICKS) ? LOCKOUT_TICKS : ENTRY_TICKS);
    localparam int TW   = $clog2(MAXT + 1);
    localparam logic [2:0] LAST = 3'(CODE_LEN - 1);

    typedef enum logic [1:0] {ST_ENTRY, ST_UNLOCKED, ST_LOCKOUT} state_t;

    state_t          state, state_n;
    logic            enter_q, press, match;
    logic            err, err_n;
    logic [TW-1:0]   timer, timer_n;
    logic            unlock_n, lockout_n;
    logic [2:0]      digit_idx_n;
    logic [FW-1:0]   fail_cnt_n, fail_inc;
    logic [3*CODE_LEN-1:0] active_code;

    function automatic logic [2:0] digit_of(input logic [3*CODE_LEN-1:0] c,
                                            input logic [2:0] idx);
        return 3'(c >> (3 * idx));
    endfunction

`ifdef LOCK_PROG_EN
    logic [3*CODE_LEN-1:0] code_q, code_n, prog_buf, prog_word;
    logic [2:0]            prog_idx, prog_idx_n;
    logic                  prog_wr;

    assign active_code = code_q;

    always_comb begin
        prog_word = prog_buf;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (prog_idx == 3'(i)) prog_word[3*i +: 3] = code_in;
        end
    end

    // Program shadow is pure data: only its write index needs a reset.
    always_ff @(posedge clk) begin
        if (prog_wr) prog_buf <= prog_word;
    end
`else
    assign active_code = CODE;
`endif

    assign press    = enter & ~enter_q;
    assign match    = (code_in == digit_of(active_code, digit_idx));
    assign fail_inc = fail_cnt + 1'b1;

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        err_n       = err;
        digit_idx_n = digit_idx;
        fail_cnt_n  = fail_cnt;
        unlock_n    = unlock;
        lockout_n   = lockout;
`ifdef LOCK_PROG_EN
        code_n      = code_q;
        prog_idx_n  = prog_idx;
        prog_wr     = 1'b0;
`endif
        case (state)
            ST_ENTRY: begin
                // A press wins over a coincident tick; wrong digits still consume the full sequence.
                if (press) begin
                    timer_n = '0;
                    if (digit_idx == LAST) begin
                        if (match && !err) begin
                            state_n    = ST_UNLOCKED;
                            unlock_n   = 1'b1;
                            fail_cnt_n = '0;
                        end else begin
                            fail_cnt_n = fail_inc;
                            if (fail_inc == FW'(MAX_FAIL)) begin
                                state_n   = ST_LOCKOUT;
                                lockout_n = 1'b1;
                            end
                        end
                        digit_idx_n = '0;
                        err_n       = 1'b0;
                    end else begin
                        digit_idx_n = digit_idx + 1'b1;
                        err_n       = err | ~match;
                    end
                end else if (tick && digit_idx != '0) begin
                    if (timer == TW'(ENTRY_TICKS - 1)) begin
                        digit_idx_n = '0;
                        err_n       = 1'b0;
                        timer_n     = '0;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
            end
            ST_UNLOCKED: begin
`ifdef LOCK_PROG_EN
                if (press) begin
                    prog_wr = 1'b1;
                    timer_n = '0;
                    if (prog_idx == LAST) begin
                        code_n     = prog_word;
                        prog_idx_n = '0;
                        state_n    = ST_ENTRY;
                        unlock_n   = 1'b0;
                    end else begin
                        prog_idx_n = prog_idx + 1'b1;
                    end
                end else if (tick) begin
                    if (timer == TW'(UNLOCK_TICKS - 1)) begin
                        state_n    = ST_ENTRY;
                        unlock_n   = 1'b0;
                        timer_n    = '0;
                        prog_idx_n = '0;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
`else
                if (tick) begin
                    if (timer == TW'(UNLOCK_TICKS - 1)) begin
                        state_n  = ST_ENTRY;
                        unlock_n = 1'b0;
                        timer_n  = '0;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
`endif
            end
            ST_LOCKOUT: begin
                if (tick) begin
                    if (timer == TW'(LOCKOUT_TICKS - 1)) begin
                        state_n    = ST_ENTRY;
                        lockout_n  = 1'b0;
                        fail_cnt_n = '0;
                        timer_n    = '0;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
            end
            default: state_n = ST_ENTRY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ENTRY;
            enter_q   <= 1'b0;
            err       <= 1'b0;
            timer     <= '0;
            digit_idx <= '0;
            fail_cnt  <= '0;
            unlock    <= 1'b0;
            lockout   <= 1'b0;
`ifdef LOCK_PROG_EN
            code_q    <= CODE;
            prog_idx  <= '0;
`endif
        end else begin
            state     <= state_n;
            enter_q   <= enter;
            err       <= err_n;
            timer     <= timer_n;
            digit_idx <= digit_idx_n;
            fail_cnt  <= fail_cnt_n;
            unlock    <= unlock_n;
            lockout   <= lockout_n;
`ifdef LOCK_PROG_EN
            code_q    <= code_n;
            prog_idx  <= prog_idx_n;
`endif
        end
    end

endmodule

// File: tb/tb_lock_sequence_ctrl.sv
// Self-checking bench for lock_sequence_ctrl against a queue-based behavioural lock model.
module tb_lock_sequence_ctrl;

    localparam int         CODE_LEN      = 3;
    localparam logic [8:0] CODE          = 9'o527;
    localparam int         MAX_FAIL      = 3;
    localparam int         UNLOCK_TICKS  = 5;
    localparam int         LOCKOUT_TICKS = 10;
    localparam int         ENTRY_TICKS   = 8;
    localparam int         FW            = $clog2(MAX_FAIL + 1);
`ifdef LOCK_PROG_EN
    localparam bit PROG = 1'b1;
`else
    localparam bit PROG = 1'b0;
`endif

    typedef struct packed {
        logic       t;
        logic       e;
        logic [2:0] c;
    } step_t;

    logic          clk = 1'b0;
    logic          rst, tick, enter;
    logic [2:0]    code_in;
    logic          unlock, lockout;
    logic [2:0]    digit_idx;
    logic [FW-1:0] fail_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    int  entered[$];
    int  prog_q[$];
    int  code_digits[CODE_LEN];
    bit  m_open, m_blocked, prev_enter;
    int  fails, idle, open_el, lock_el;

    step_t steps[$];

    always #5 clk = ~clk;

    lock_sequence_ctrl #(
        .CODE_LEN(CODE_LEN), .CODE(CODE), .MAX_FAIL(MAX_FAIL),
        .UNLOCK_TICKS(UNLOCK_TICKS), .LOCKOUT_TICKS(LOCKOUT_TICKS), .ENTRY_TICKS(ENTRY_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .enter(enter), .code_in(code_in),
        .unlock(unlock), .lockout(lockout), .digit_idx(digit_idx), .fail_cnt(fail_cnt)
    );

    task automatic model_reset();
        logic [8:0] c;
        c = CODE;
        entered.delete();
        prog_q.delete();
        for (int i = 0; i < CODE_LEN; i++) code_digits[i] = int'((c >> (3 * i)) & 9'h7);
        m_open = 0; m_blocked = 0; prev_enter = 0;
        fails = 0; idle = 0; open_el = 0; lock_el = 0;
    endtask

    task automatic model_step(input bit t, input bit e, input logic [2:0] c);
        bit press, ok;
        press      = e && !prev_enter;
        prev_enter = e;
        if (m_blocked) begin
            if (t) begin
                lock_el++;
                if (lock_el == LOCKOUT_TICKS) begin m_blocked = 0; fails = 0; end
            end
        end else if (m_open) begin
            if (PROG && press) begin
                prog_q.push_back(int'(c));
                open_el = 0;
                if (prog_q.size() == CODE_LEN) begin
                    for (int i = 0; i < CODE_LEN; i++) code_digits[i] = prog_q[i];
                    prog_q.delete();
                    m_open = 0;
                end
            end else if (t) begin
                open_el++;
                if (open_el == UNLOCK_TICKS) begin m_open = 0; prog_q.delete(); end
            end
        end else if (press) begin
            entered.push_back(int'(c));
            idle = 0;
            if (entered.size() == CODE_LEN) begin
                ok = 1;
                for (int i = 0; i < CODE_LEN; i++) if (entered[i] != code_digits[i]) ok = 0;
                entered.delete();
                if (ok) begin
                    m_open = 1; open_el = 0; fails = 0;
                end else begin
                    fails++;
                    if (fails == MAX_FAIL) begin m_blocked = 1; lock_el = 0; end
                end
            end
        end else if (t && entered.size() != 0) begin
            idle++;
            if (idle == ENTRY_TICKS) begin entered.delete(); idle = 0; end
        end
    endtask

    function automatic logic [4+FW:0] exp_vec();
        return {m_open, m_blocked, 3'(entered.size()), FW'(fails)};
    endfunction

    function automatic step_t mk(input bit t, input bit e, input logic [2:0] c);
        step_t s;
        s.t = t; s.e = e; s.c = c;
        return s;
    endfunction

    function automatic void add_press(input logic [2:0] c);
        steps.push_back(mk(1'b0, 1'b1, c));
        steps.push_back(mk(1'b0, 1'b0, 3'd0));
    endfunction

    function automatic void add_ticks(input int n);
        for (int i = 0; i < n; i++) steps.push_back(mk(1'b1, 1'b0, 3'd0));
    endfunction

    task automatic apply(input bit t, input bit e, input logic [2:0] c);
        tick = t; enter = e; code_in = c;
        model_step(t, e, c);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; tick = 1'b0; enter = 1'b0; code_in = 3'd0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b1; enter = 1'b1; code_in = 3'd7;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({unlock, lockout, digit_idx, fail_cnt} !== '0) begin
                miscompares++;
                $display("FAIL reset_hold: got %b want all zero", {unlock, lockout, digit_idx, fail_cnt});
            end
        end
        enter = 1'b0; tick = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_unlock();
        int m_open_at, m_still, m_closed;
        reset_dut();
        steps.delete();
        add_press(3'd7); add_press(3'd2);
        steps.push_back(mk(1'b0, 1'b1, 3'd5)); m_open_at = steps.size() - 1;
        steps.push_back(mk(1'b0, 1'b0, 3'd0));
        add_ticks(4); m_still = steps.size() - 1;
        add_ticks(1); m_closed = steps.size() - 1;
        foreach (steps[i]) begin
            apply(steps[i].t, steps[i].e, steps[i].c);
            vectors++;
            if ({unlock, lockout, digit_idx, fail_cnt} !== exp_vec()) begin
                miscompares++;
                $display("FAIL unlock_step%0d: got %b want %b", i, {unlock, lockout, digit_idx, fail_cnt}, exp_vec());
            end
            if (i == m_open_at) begin
                vectors++;
                if (unlock !== 1'b1 || fail_cnt !== '0) begin
                    miscompares++;
                    $display("FAIL unlock_open: got unlock=%b fail=%0d want 1/0", unlock, fail_cnt);
                end
            end
            if (i == m_still) begin
                vectors++;
                if (unlock !== 1'b1) begin
                    miscompares++;
                    $display("FAIL unlock_hold4: got %b want 1", unlock);
                end
            end
            if (i == m_closed) begin
                vectors++;
                if (unlock !== 1'b0) begin
                    miscompares++;
                    $display("FAIL unlock_expire: got %b want 0", unlock);
                end
            end
        end
    endtask

    task automatic test_wrong_then_right();
        int m_a, m_b;
        reset_dut();
        steps.delete();
        add_press(3'd7); add_press(3'd3); add_press(3'd5); m_a = steps.size() - 1;
        add_press(3'd7); add_press(3'd2); add_press(3'd5); m_b = steps.size() - 1;
        foreach (steps[i]) begin
            apply(steps[i].t, steps[i].e, steps[i].c);
            vectors++;
            if ({unlock, lockout, digit_idx, fail_cnt} !== exp_vec()) begin
                miscompares++;
                $display("FAIL wrong_right_step%0d: got %b want %b", i, {unlock, lockout, digit_idx, fail_cnt}, exp_vec());
            end
            if (i == m_a) begin
                vectors++;
                if (unlock !== 1'b0 || fail_cnt !== FW'(1) || digit_idx !== 3'd0) begin
                    miscompares++;
                    $display("FAIL wrong_attempt: got u=%b f=%0d d=%0d want 0/1/0", unlock, fail_cnt, digit_idx);
                end
            end
            if (i == m_b) begin
                vectors++;
                if (unlock !== 1'b1 || fail_cnt !== '0) begin
                    miscompares++;
                    $display("FAIL right_attempt: got u=%b f=%0d want 1/0", unlock, fail_cnt);
                end
            end
        end
    endtask

    task automatic test_lockout();
        int m_a, m_b, m_c, m_d;
        reset_dut();
        steps.delete();
        for (int k = 0; k < 3; k++) begin add_press(3'd1); add_press(3'd1); add_press(3'd1); end
        m_a = steps.size() - 1;
        add_press(3'd7); add_press(3'd2); add_press(3'd5); m_b = steps.size() - 1;
        add_ticks(9); m_c = steps.size() - 1;
        steps.push_back(mk(1'b0, 1'b1, 3'd7));
        steps.push_back(mk(1'b1, 1'b1, 3'd7));
        steps.push_back(mk(1'b0, 1'b1, 3'd7)); m_d = steps.size() - 1;
        steps.push_back(mk(1'b0, 1'b0, 3'd0));
        foreach (steps[i]) begin
            apply(steps[i].t, steps[i].e, steps[i].c);
            vectors++;
            if ({unlock, lockout, digit_idx, fail_cnt} !== exp_vec()) begin
                miscompares++;
                $display("FAIL lockout_step%0d: got %b want %b", i, {unlock, lockout, digit_idx, fail_cnt}, exp_vec());
            end
            if (i == m_a) begin
                vectors++;
                if (lockout !== 1'b1 || fail_cnt !== FW'(3)) begin
                    miscompares++;
                    $display("FAIL lockout_enter: got l=%b f=%0d want 1/3", lockout, fail_cnt);
                end
            end
            if (i == m_b) begin
                vectors++;
                if (unlock !== 1'b0 || lockout !== 1'b1) begin
                    miscompares++;
                    $display("FAIL lockout_ignore: got u=%b l=%b want 0/1", unlock, lockout);
                end
            end
            if (i == m_c) begin
                vectors++;
                if (lockout !== 1'b1) begin
                    miscompares++;
                    $display("FAIL lockout_9ticks: got %b want 1", lockout);
                end
            end
            if (i == m_d) begin
                vectors++;
                if (lockout !== 1'b0 || fail_cnt !== '0 || digit_idx !== 3'd0) begin
                    miscompares++;
                    $display("FAIL lockout_exit_held: got l=%b f=%0d d=%0d want 0/0/0", lockout, fail_cnt, digit_idx);
                end
            end
        end
    endtask

    task automatic test_timeout_hold();
        int m_a, m_b, m_c, m_d, m_e;
        reset_dut();
        steps.delete();
        add_press(3'd1); add_press(3'd1); add_press(3'd1);
        add_press(3'd7); m_a = steps.size() - 1;
        add_ticks(7); m_b = steps.size() - 1;
        add_ticks(1); m_c = steps.size() - 1;
        for (int k = 0; k < 20; k++) steps.push_back(mk(1'b0, 1'b1, 3'd7));
        m_d = steps.size() - 1;
        steps.push_back(mk(1'b0, 1'b0, 3'd0));
        add_ticks(7);
        steps.push_back(mk(1'b1, 1'b1, 3'd2));
        steps.push_back(mk(1'b0, 1'b0, 3'd0));
        add_ticks(7); m_e = steps.size() - 1;
        add_ticks(1);
        foreach (steps[i]) begin
            apply(steps[i].t, steps[i].e, steps[i].c);
            vectors++;
            if ({unlock, lockout, digit_idx, fail_cnt} !== exp_vec()) begin
                miscompares++;
                $display("FAIL timeout_step%0d: got %b want %b", i, {unlock, lockout, digit_idx, fail_cnt}, exp_vec());
            end
            if (i == m_a || i == m_b || i == m_d) begin
                vectors++;
                if (digit_idx !== 3'd1) begin
                    miscompares++;
                    $display("FAIL timeout_idx1_at%0d: got %0d want 1", i, digit_idx);
                end
            end
            if (i == m_c) begin
                vectors++;
                if (digit_idx !== 3'd0 || fail_cnt !== FW'(1)) begin
                    miscompares++;
                    $display("FAIL timeout_discard: got d=%0d f=%0d want 0/1", digit_idx, fail_cnt);
                end
            end
            if (i == m_e) begin
                vectors++;
                if (digit_idx !== 3'd2) begin
                    miscompares++;
                    $display("FAIL tick_press_same: got %0d want 2", digit_idx);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        steps.delete();
        add_press(3'd7); add_press(3'd2); add_press(3'd5); add_ticks(2);
        foreach (steps[i]) apply(steps[i].t, steps[i].e, steps[i].c);
        vectors++;
        if (unlock !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_pre_unlock: got %b want 1", unlock);
        end
        rst = 1'b1;
        #2;
        vectors++;
        if ({unlock, lockout, digit_idx, fail_cnt} !== '0) begin
            miscompares++;
            $display("FAIL arst_unlocked: got %b want all zero", {unlock, lockout, digit_idx, fail_cnt});
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        steps.delete();
        for (int k = 0; k < 3; k++) begin add_press(3'd0); add_press(3'd0); add_press(3'd0); end
        add_ticks(3);
        foreach (steps[i]) apply(steps[i].t, steps[i].e, steps[i].c);
        vectors++;
        if (lockout !== 1'b1 || fail_cnt !== FW'(3)) begin
            miscompares++;
            $display("FAIL arst_pre_lockout: got l=%b f=%0d want 1/3", lockout, fail_cnt);
        end
        rst = 1'b1;
        #2;
        vectors++;
        if ({unlock, lockout, digit_idx, fail_cnt} !== '0) begin
            miscompares++;
            $display("FAIL arst_lockout: got %b want all zero", {unlock, lockout, digit_idx, fail_cnt});
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

`ifdef LOCK_PROG_EN
    task automatic test_prog();
        int m_a, m_b, m_c, m_d;
        reset_dut();
        steps.delete();
        add_press(3'd7); add_press(3'd2); add_press(3'd5);
        add_press(3'd1); add_press(3'd1); add_press(3'd0); m_a = steps.size() - 1;
        add_press(3'd7); add_press(3'd2); add_press(3'd5); m_b = steps.size() - 1;
        add_press(3'd1); add_press(3'd1); add_press(3'd0); m_c = steps.size() - 1;
        foreach (steps[i]) begin
            apply(steps[i].t, steps[i].e, steps[i].c);
            vectors++;
            if ({unlock, lockout, digit_idx, fail_cnt} !== exp_vec()) begin
                miscompares++;
                $display("FAIL prog_step%0d: got %b want %b", i, {unlock, lockout, digit_idx, fail_cnt}, exp_vec());
            end
            if (i == m_a) begin
                vectors++;
                if (unlock !== 1'b0) begin
                    miscompares++;
                    $display("FAIL prog_done: got %b want 0", unlock);
                end
            end
            if (i == m_b) begin
                vectors++;
                if (unlock !== 1'b0 || fail_cnt !== FW'(1)) begin
                    miscompares++;
                    $display("FAIL prog_old_code: got u=%b f=%0d want 0/1", unlock, fail_cnt);
                end
            end
            if (i == m_c) begin
                vectors++;
                if (unlock !== 1'b1) begin
                    miscompares++;
                    $display("FAIL prog_new_code: got %b want 1", unlock);
                end
            end
        end
        reset_dut();
        steps.delete();
        add_press(3'd7); add_press(3'd2); add_press(3'd5); m_d = steps.size() - 1;
        foreach (steps[i]) begin
            apply(steps[i].t, steps[i].e, steps[i].c);
            if (i == m_d) begin
                vectors++;
                if (unlock !== 1'b1) begin
                    miscompares++;
                    $display("FAIL prog_revert: got %b want 1", unlock);
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        bit t, e;
        logic [2:0] c;
        reset_dut();
        e = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            t = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) e = ~e;
            if ($urandom_range(0, 9) < 7 && !m_open && entered.size() < CODE_LEN)
                c = 3'(code_digits[entered.size()]);
            else
                c = 3'($urandom_range(0, 7));
            apply(t, e, c);
            vectors++;
            if ({unlock, lockout, digit_idx, fail_cnt} !== exp_vec()) begin
                miscompares++;
                $display("FAIL random_cycle%0d: got %b want %b", i, {unlock, lockout, digit_idx, fail_cnt}, exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; enter = 1'b0; code_in = 3'd0;
        test_reset();
        test_unlock();
        test_wrong_then_right();
        test_lockout();
        test_timeout_hold();
        test_async_reset();
`ifdef LOCK_PROG_EN
        test_prog();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
